// File: rtl/tlc_conflict_monitor.sv
// tlc_conflict_monitor: traffic-light lamp safety monitor with fault flash and all-red recovery.
// Define TLC_MON_WATCHDOG_EN to add the stuck-phase watchdog (fault_code 5).
module tlc_conflict_monitor #(
   parameter int MIN_YELLOW    = 3,
   parameter int FLASH_HALF    = 4,
   parameter int ALLRED_CYCLES = 2,
   parameter int MAX_PHASE     = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] highway_lights,
   input  logic [2:0] country_lights,
   input  logic       fault_clear,
   output logic [2:0] highway_lamps,
   output logic [2:0] country_lamps,
   output logic       fault,
   output logic [2:0] fault_code
);
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] R = 3'b100;
   localparam int FW = $clog2(2 * FLASH_HALF);
   localparam int RW = $clog2(ALLRED_CYCLES + 1);
   localparam logic [3:0]    MY     = 4'(MIN_YELLOW);
   localparam logic [FW-1:0] F_LAST = FW'(2 * FLASH_HALF - 1);
   localparam logic [FW-1:0] F_HALF = FW'(FLASH_HALF);
   localparam logic [RW-1:0] R_LAST = RW'(ALLRED_CYCLES - 1);

   typedef enum logic [1:0] {ST_MONITOR, ST_FAULT, ST_RECOVER} state_t;

   state_t        state;
   logic [2:0]    prev_hw, prev_cw;
   logic [3:0]    ycnt_hw, ycnt_cw;
   logic [FW-1:0] flash_cnt, flash_next;
   logic [RW-1:0] rec_cnt;
   logic          v1, v2, v3, v4, v5, trip;
   logic [2:0]    safe_code, mon_code, trip_code;

   function automatic logic onehot(input logic [2:0] v);
      return v == G || v == Y || v == R;
   endfunction

   function automatic logic legal(input logic [2:0] p, input logic [2:0] n);
      return n == p || (p == G && n == Y) || (p == Y && n == R) || (p == R && n == G);
   endfunction

   function automatic logic [3:0] ynext(input logic [3:0] cnt, input logic [2:0] v);
      return v == Y ? (cnt == 4'hF ? cnt : cnt + 4'd1) : 4'd0;
   endfunction

   always_comb begin
      v1 = !onehot(highway_lights) || !onehot(country_lights);
      v2 = highway_lights != R && country_lights != R;
      v3 = !legal(prev_hw, highway_lights) || !legal(prev_cw, country_lights);
      v4 = (prev_hw == Y && highway_lights == R && ycnt_hw < MY) ||
           (prev_cw == Y && country_lights == R && ycnt_cw < MY);
      safe_code = v1 ? 3'd1 : v2 ? 3'd2 : 3'd0;
      mon_code = safe_code != 3'd0 ? safe_code : v3 ? 3'd3 : v4 ? 3'd4 : v5 ? 3'd5 : 3'd0;
      trip = (state == ST_MONITOR && mon_code != 3'd0) || (state == ST_RECOVER && safe_code != 3'd0);
      trip_code = state == ST_RECOVER ? safe_code : mon_code;
      flash_next = flash_cnt == F_LAST ? '0 : flash_cnt + 1'b1;
   end

`ifdef TLC_MON_WATCHDOG_EN
   localparam int WW = $clog2(MAX_PHASE + 1);
   localparam logic [WW-1:0] W_LIM = WW'(MAX_PHASE);
   logic [WW-1:0] wd_cnt;
   logic          same;

   // wd_cnt holds the length of the current phase, the changing cycle included
   assign same = highway_lights == prev_hw && country_lights == prev_cw;
   assign v5   = same && wd_cnt + 1'b1 == W_LIM;

   always_ff @(posedge clk) begin
      if (reset || state != ST_MONITOR)
         wd_cnt <= '0;
      else
         wd_cnt <= same ? wd_cnt + 1'b1 : WW'(1);
   end
`else
   assign v5 = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_MONITOR;
         highway_lamps <= R;
         country_lamps <= R;
         fault         <= 1'b0;
         fault_code    <= 3'd0;
         prev_hw       <= R;
         prev_cw       <= R;
         ycnt_hw       <= 4'd0;
         ycnt_cw       <= 4'd0;
         flash_cnt     <= '0;
         rec_cnt       <= '0;
      end else if (trip) begin
         state         <= ST_FAULT;
         fault         <= 1'b1;
         fault_code    <= trip_code;
         highway_lamps <= R;
         country_lamps <= R;
         flash_cnt     <= '0;
      end else begin
         case (state)
            ST_MONITOR: begin
               highway_lamps <= highway_lights;
               country_lamps <= country_lights;
               prev_hw       <= highway_lights;
               prev_cw       <= country_lights;
               ycnt_hw       <= ynext(ycnt_hw, highway_lights);
               ycnt_cw       <= ynext(ycnt_cw, country_lights);
            end
            ST_FAULT: begin
               if (fault_clear && safe_code == 3'd0) begin
                  state         <= ST_RECOVER;
                  fault         <= 1'b0;
                  fault_code    <= 3'd0;
                  highway_lamps <= R;
                  country_lamps <= R;
                  rec_cnt       <= '0;
                  prev_hw       <= highway_lights;
                  prev_cw       <= country_lights;
                  ycnt_hw       <= MY;
                  ycnt_cw       <= MY;
               end else begin
                  flash_cnt     <= flash_next;
                  highway_lamps <= flash_next < F_HALF ? R : 3'b000;
                  country_lamps <= flash_next < F_HALF ? R : 3'b000;
               end
            end
            ST_RECOVER: begin
               // sequence history is rebuilt here so MONITOR resumes without false trips
               prev_hw <= highway_lights;
               prev_cw <= country_lights;
               ycnt_hw <= MY;
               ycnt_cw <= MY;
               if (rec_cnt == R_LAST) begin
                  state         <= ST_MONITOR;
                  highway_lamps <= highway_lights;
                  country_lamps <= country_lights;
               end else begin
                  rec_cnt <= rec_cnt + 1'b1;
               end
            end
            default: state <= ST_MONITOR;
         endcase
      end
   end
endmodule

// File: doc/tlc_conflict_monitor.md
TLC_CONFLICT_MONITOR -- requirements
Module: tlc_conflict_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 3: minimum legal consecutive yellow cycles per side.
REQ-002 Parameter FLASH_HALF, default 4: cycles per half-period of the fault red flash.
REQ-003 Parameter ALLRED_CYCLES, default 2: solid all-red cycles in RECOVER.
REQ-004 Parameter MAX_PHASE, default 64: watchdog limit in cycles, used only with the watchdog compiled in.
REQ-005 clk  input  1  single clock; all logic SHALL sample on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 highway_lights  input  3  controller highway lamp request; 001 green, 010 yellow, 100 red.
REQ-008 country_lights  input  3  controller country lamp request; same encoding.
REQ-009 fault_clear  input  1  operator request to leave FAULT; level-sampled.
REQ-010 highway_lamps  output  3  registered highway lamp drive.
REQ-011 country_lamps  output  3  registered country lamp drive.
REQ-012 fault  output  1  high while in FAULT.
REQ-013 fault_code  output  3  latched cause: 0 none, 1 illegal encoding, 2 conflict, 3 bad sequence, 4 short yellow, 5 watchdog.

Function
REQ-014 The block SHALL implement three states: MONITOR, FAULT and RECOVER.
REQ-015 In MONITOR, the lamp outputs SHALL equal the inputs sampled at the previous edge, giving 1-cycle latency.
REQ-016 An input vector that is not one-hot SHALL be violation 1.
REQ-017 Any cycle where neither side is 100 SHALL be violation 2.
REQ-018 Per side, only G->Y, Y->R, R->G and unchanged are legal versus the previous sampled value; any other change SHALL be violation 3.
REQ-019 Per side, a 4-bit saturating counter SHALL count consecutive yellow cycles; a Y->R change with count < MIN_YELLOW SHALL be violation 4.
REQ-020 Violations SHALL be evaluated every MONITOR cycle; when several coincide, the lowest code SHALL be latched.
REQ-021 On the edge that samples a violation, the block SHALL enter FAULT with fault=1, fault_code latched, both lamps 100 and the flash counter at 0.
REQ-022 In FAULT, both lamps SHALL show 100 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, repeating.
REQ-023 In FAULT, fault_clear=1 with inputs free of violations 1 and 2 SHALL enter RECOVER at the next edge; otherwise fault_clear SHALL be ignored.
REQ-024 On entering RECOVER, fault and fault_code SHALL clear to 0, and both lamps SHALL be solid 100 for ALLRED_CYCLES cycles, after which the block SHALL enter MONITOR.
REQ-025 In RECOVER, the previous-value registers SHALL track the inputs without sequence checks, and the yellow counters SHALL be held at MIN_YELLOW.
REQ-026 In RECOVER, violations 1 and 2 SHALL re-enter FAULT immediately; violations 3 and 4 SHALL not be checked.
REQ-027 In MONITOR, fault_clear SHALL have no effect.

Reset
REQ-028 Reset SHALL force MONITOR, both lamps 100, fault=0, fault_code=0, previous-value registers 100/100, yellow counters 0, flash and recover counters 0, and the watchdog counter 0.
REQ-029 Reset SHALL override every other input in the same cycle, including mid-FAULT and mid-RECOVER.

Configuration
REQ-030 Macro TLC_MON_WATCHDOG_EN defined: in MONITOR, a counter SHALL count cycles with both inputs unchanged and reset on any change; reaching MAX_PHASE SHALL be violation 5.
REQ-031 Macro undefined: no watchdog counter SHALL exist and fault_code 5 SHALL never occur.

Verification
REQ-032 Reset, then drive the controller pattern (hw G 8 cycles, Y 3, R with country G 8, Y 3) for 3 loops -> lamps equal inputs delayed 1 cycle; fault=0 throughout.
REQ-033 Drive hw=001 and country=001 -> next edge fault=1, code=2, lamps 100/100 for 4 cycles, then 000/000 for 4 cycles, repeating.
REQ-034 Drive hw 001->100 with country 100 -> code=3; drive hw 010 for 2 cycles then 100 -> code=4; drive hw=011 together with a conflict -> code=1.
REQ-035 In FAULT, fault_clear=1 with inputs 001/001 -> stays in FAULT; fault_clear=1 with inputs 001/100 -> fault=0, lamps 100/100 for 2 cycles, then MONITOR pass-through.
REQ-036 With TLC_MON_WATCHDOG_EN defined, hold 001/100 for 64 cycles -> fault=1, code=5; without the macro, hold for 200 cycles -> fault=0.
